// File: rtl/posit_mult_stage.sv
// posit_mult_stage: two-stage SIMD posit multiply core (sign XOR, scale sum, mantissa product).
// Define POSIT_MULT_PERF_CNT_EN to add the 32-bit output-transfer counter on perf_cnt.
module posit_mult_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  mode,
    input  logic [3:0]  a_s,
    input  logic [3:0]  b_s,
    input  logic [15:0] a_rg_exp,
    input  logic [15:0] b_rg_exp,
    input  logic [27:0] a_mant,
    input  logic [27:0] b_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_mode,
    output logic [3:0]  out_s,
    output logic [19:0] out_sc,
`ifdef POSIT_MULT_PERF_CNT_EN
    output logic [31:0] perf_cnt,
`endif
    output logic [55:0] out_prod
);

    logic        r_s1_valid;
    logic [1:0]  r_s1_mode;
    logic [3:0]  r_s1_s;
    logic [19:0] r_s1_sc;
    logic [27:0] r_s1_a_mant;
    logic [27:0] r_s1_b_mant;

    logic        r_s2_valid;
    logic [1:0]  r_s2_mode;
    logic [3:0]  r_s2_s;
    logic [19:0] r_s2_sc;
    logic [55:0] r_s2_prod;

    logic        w_s1_load;
    logic        w_s2_load;
    logic        w_out_fire;

    logic [4:0]  w_sc8 [4];
    logic [9:0]  w_sc16 [2];
    logic [16:0] w_sum32;
    logic [19:0] w_sc32;
    logic [19:0] w_sc;

    logic [13:0] w_p8 [4];
    logic [27:0] w_p16 [2];
    logic [55:0] w_p32;
    logic [55:0] w_prod;

    // A stage may load when its successor is empty or is being drained this cycle.
    assign in_ready   = !r_s1_valid || !r_s2_valid || out_ready;
    assign w_s1_load  = in_valid && in_ready;
    assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);
    assign w_out_fire = r_s2_valid && out_ready;

    // Scale sums: each lane is sign-extended by one bit before adding, so no carry leaves a lane.
    genvar g;
    for (g = 0; g < 4; g++) begin : g_sc8
        assign w_sc8[g] = {a_rg_exp[4*g+3], a_rg_exp[4*g +: 4]}
                        + {b_rg_exp[4*g+3], b_rg_exp[4*g +: 4]};
    end

    for (g = 0; g < 2; g++) begin : g_sc16
        logic [8:0] w_sum;
        assign w_sum     = {a_rg_exp[8*g+7], a_rg_exp[8*g +: 8]}
                         + {b_rg_exp[8*g+7], b_rg_exp[8*g +: 8]};
        assign w_sc16[g] = {w_sum[8], w_sum};
    end

    assign w_sum32 = {a_rg_exp[15], a_rg_exp} + {b_rg_exp[15], b_rg_exp};
    assign w_sc32  = {{3{w_sum32[16]}}, w_sum32};

    always_comb begin
        w_sc = w_sc32;
        case (mode)
            2'b00:   w_sc = {w_sc8[3], w_sc8[2], w_sc8[1], w_sc8[0]};
            2'b01:   w_sc = {w_sc16[1], w_sc16[0]};
            default: w_sc = w_sc32;
        endcase
    end

    // Mantissa products from the S1 operands; each lane product fills its field exactly.
    for (g = 0; g < 4; g++) begin : g_p8
        assign w_p8[g] = {7'd0, r_s1_a_mant[7*g +: 7]} * {7'd0, r_s1_b_mant[7*g +: 7]};
    end

    for (g = 0; g < 2; g++) begin : g_p16
        assign w_p16[g] = {14'd0, r_s1_a_mant[14*g +: 14]} * {14'd0, r_s1_b_mant[14*g +: 14]};
    end

    assign w_p32 = {28'd0, r_s1_a_mant} * {28'd0, r_s1_b_mant};

    always_comb begin
        w_prod = w_p32;
        case (r_s1_mode)
            2'b00:   w_prod = {w_p8[3], w_p8[2], w_p8[1], w_p8[0]};
            2'b01:   w_prod = {w_p16[1], w_p16[0]};
            default: w_prod = w_p32;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= 2'd0;
            r_s1_s      <= 4'd0;
            r_s1_sc     <= 20'd0;
            r_s1_a_mant <= 28'd0;
            r_s1_b_mant <= 28'd0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid  <= 1'b1;
                r_s1_mode   <= mode;
                r_s1_s      <= a_s ^ b_s;
                r_s1_sc     <= w_sc;
                r_s1_a_mant <= a_mant;
                r_s1_b_mant <= b_mant;
            end else if (w_s2_load) begin
                r_s1_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_mode  <= 2'd0;
            r_s2_s     <= 4'd0;
            r_s2_sc    <= 20'd0;
            r_s2_prod  <= 56'd0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_mode  <= r_s1_mode;
                r_s2_s     <= r_s1_s;
                r_s2_sc    <= r_s1_sc;
                r_s2_prod  <= w_prod;
            end else if (w_out_fire) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_mode  = r_s2_mode;
    assign out_s     = r_s2_s;
    assign out_sc    = r_s2_sc;
    assign out_prod  = r_s2_prod;

`ifdef POSIT_MULT_PERF_CNT_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cnt <= 32'd0;
        end else if (w_out_fire) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign perf_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_posit_mult_stage.sv
// tb_posit_mult_stage: directed vector table plus backpressure, reset-in-flight and counter sequences.
// The counter sequence is built only when POSIT_MULT_PERF_CNT_EN is defined.
module tb_posit_mult_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [3:0]  a_s, b_s;
    logic [15:0] a_rg_exp, b_rg_exp;
    logic [27:0] a_mant, b_mant;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_mode;
    logic [3:0]  out_s;
    logic [19:0] out_sc;
    logic [55:0] out_prod;
`ifdef POSIT_MULT_PERF_CNT_EN
    logic [31:0] perf_cnt;
`endif

    posit_mult_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a_s(a_s), .b_s(b_s),
        .a_rg_exp(a_rg_exp), .b_rg_exp(b_rg_exp),
        .a_mant(a_mant), .b_mant(b_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mode(out_mode), .out_s(out_s), .out_sc(out_sc),
`ifdef POSIT_MULT_PERF_CNT_EN
        .perf_cnt(perf_cnt),
`endif
        .out_prod(out_prod)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  a_s, b_s;
        logic [15:0] a_rg, b_rg;
        logic [27:0] a_mant, b_mant;
        logic [3:0]  exp_s;
        logic [19:0] exp_sc;
        logic [55:0] exp_prod;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        mode     = v.mode;
        a_s      = v.a_s;
        b_s      = v.b_s;
        a_rg_exp = v.a_rg;
        b_rg_exp = v.b_rg;
        a_mant   = v.a_mant;
        b_mant   = v.b_mant;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        check({tag, " valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, " mode"},  {62'd0, out_mode},  {62'd0, v.mode});
        check({tag, " s"},     {60'd0, out_s},     {60'd0, v.exp_s});
        check({tag, " sc"},    {44'd0, out_sc},    {44'd0, v.exp_sc});
        check({tag, " prod"},  {8'd0, out_prod},   {8'd0, v.exp_prod});
    endtask

    initial begin
        // mode 1x unit case: 1.0 * 1.0 with scales 3 and -2
        vecs[0] = '{2'b10, 4'h8, 4'h0, 16'h0003, 16'hFFFE, 28'h8000000, 28'h8000000,
                    4'h8, 20'h00001, 56'h40000000000000};
        // mode 00 all-ones lanes: no carry may cross a 14-bit or 5-bit lane
        vecs[1] = '{2'b00, 4'hA, 4'h6, 16'h7777, 16'h7777, 28'hFFFFFFF, 28'hFFFFFFF,
                    4'hC, {4{5'h0E}}, {4{14'h3F01}}};
        // mode 01 extremes; scale lanes -128+-128 and 127+1
        vecs[2] = '{2'b01, 4'hF, 4'h3, {8'h7F, 8'h80}, {8'h01, 8'h80},
                    {14'h2000, 14'h3FFF}, {14'h2000, 14'h3FFF},
                    4'hC, {10'h080, 10'h300}, {28'h4000000, 28'hFFF8001}};
        // mode 00 mixed-sign scales and zero/one mantissas
        vecs[3] = '{2'b00, 4'h0, 4'hF, 16'h07F8, 16'h3918,
                    {7'h55, 7'h7F, 7'h01, 7'h40}, {7'h02, 7'h00, 7'h7F, 7'h40},
                    4'hF, {5'h03, 5'h00, 5'h00, 5'h10}, {14'h00AA, 14'h0000, 14'h007F, 14'h1000}};
        // mode 11 max mantissa and most negative scale
        vecs[4] = '{2'b11, 4'h5, 4'hF, 16'h8000, 16'h8000, 28'hFFFFFFF, 28'hFFFFFFF,
                    4'hA, 20'hF0000, 56'hFFFFFFE0000001};
        // mode 01 scale overflow into the 10-bit lane (254, -2)
        vecs[5] = '{2'b01, 4'h0, 4'h0, {8'hFF, 8'h7F}, {8'hFF, 8'h7F},
                    {14'h0003, 14'h0002}, {14'h0005, 14'h1000},
                    4'h0, {10'h3FE, 10'h0FE}, {28'h000000F, 28'h0002000}};
        // mode 10 small values cancelling scales
        vecs[6] = '{2'b10, 4'h1, 4'h1, 16'h0010, 16'hFFF0, 28'h0000003, 28'h0000007,
                    4'h0, 20'h00000, 56'h15};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(vecs[6]);
        #12;
        check("rst out_valid", {63'd0, out_valid}, 64'd0);
        check("rst in_ready",  {63'd0, in_ready},  64'd1);
        check("rst out_prod",  {8'd0, out_prod},   64'd0);
        check("rst out_sc",    {44'd0, out_sc},    64'd0);
        check("rst out_mode",  {62'd0, out_mode},  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one operand pair at a time, out_ready held high.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d early valid", i), {63'd0, out_valid}, 64'd0);
            @(negedge clk);
            check_out($sformatf("v%0d", i), vecs[i]);
        end
        @(negedge clk);
        check("drain valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: three back-to-back offers with the consumer stalled.
        out_ready = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        check("bp ready0", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        drive(vecs[1]);
        check("bp ready1", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        drive(vecs[2]);
        check("bp ready2", {63'd0, in_ready}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp stall ready", {63'd0, in_ready}, 64'd0);
            check_out("bp hold", vecs[0]);
        end
        out_ready = 1'b1;
        #1;
        check("bp release ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("bp r1", vecs[1]);
        @(negedge clk);
        check_out("bp r2", vecs[2]);
        @(negedge clk);
        check("bp empty", {63'd0, out_valid}, 64'd0);

        // Reset one cycle after an input transfer; the operation must vanish.
        drive(vecs[3]);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rif pre valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rif valid", {63'd0, out_valid}, 64'd0);
        check("rif ready", {63'd0, in_ready},  64'd1);
        check("rif prod",  {8'd0, out_prod},   64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("rif no output", seen, 0);
        end

`ifdef POSIT_MULT_PERF_CNT_EN
        @(negedge clk);
        force dut.r_perf_cnt = 32'hFFFFFFFE;
        #1;
        release dut.r_perf_cnt;
        drive(vecs[6]);
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("pc pre", {32'd0, perf_cnt}, 64'hFFFFFFFE);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("pc 1", {32'd0, perf_cnt}, 64'hFFFFFFFF);
        @(negedge clk);
        check("pc 2", {32'd0, perf_cnt}, 64'h00000000);
        @(negedge clk);
        check("pc 3", {32'd0, perf_cnt}, 64'h00000001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/posit_mult_stage.md
POSIT_MULT_STAGE -- requirements
Module: posit_mult_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: operand pair valid.
REQ-004 SHALL have port in_ready, output, 1 bit: stage accepts the operand pair.
REQ-005 SHALL have port mode, input, 2 bits: 00 = 4x8-bit lanes, 01 = 2x16-bit lanes, 10 and 11 = 1x32-bit lane.
REQ-006 SHALL have ports a_s and b_s, input, 4 bits each: per-lane sign from extraction.
REQ-007 SHALL have ports a_rg_exp and b_rg_exp, input, 16 bits each: per-lane two's-complement scale (regime and exponent) from extraction.
REQ-008 SHALL have ports a_mant and b_mant, input, 28 bits each: per-lane mantissa with hidden one, from extraction.
REQ-009 SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port out_mode, output, 2 bits: mode travelling with the result.
REQ-012 SHALL have port out_s, output, 4 bits: per-lane product sign.
REQ-013 SHALL have port out_sc, output, 20 bits: per-lane scale sum.
REQ-014 SHALL have port out_prod, output, 56 bits: per-lane mantissa product.

Function
REQ-015 SHALL transfer an input when in_valid and in_ready are both 1 on a clk edge, and an output when out_valid and out_ready are both 1.
REQ-016 SHALL be a 2-stage pipeline: stage S1 registers the operands, sign XOR and scale sum; stage S2 registers the mantissa product.
- Latency: 2 cycles from input transfer to out_valid.
- Throughput: 1 result per cycle while out_ready=1.
REQ-017 SHALL drive in_ready = !s1_valid | !s2_valid | out_ready, combinationally.
- Each stage advances when its successor is empty or is being drained.
- No pipeline bubble when the pipeline is full and out_ready=1.
REQ-018 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-019 SHALL compute out_s[i] = a_s[i] ^ b_s[i] for all 4 bits in every mode; unused lanes are don't-care but deterministic.
REQ-020 SHALL compute the scale sum per mode as follows:
- mode 00: out_sc[5i+4:5i] = sext(a_rg_exp[4i+3:4i]) + sext(b_rg_exp[4i+3:4i]), for i = 0..3.
- mode 01: out_sc[10i+9:10i] = 10-bit sext of the 8-bit lane sum, for i = 0..1.
- mode 1x: out_sc = 20-bit sext of the 16-bit sum.
REQ-021 SHALL compute the mantissa product per mode as follows:
- mode 00: out_prod[14i+13:14i] = a_mant[7i+6:7i] * b_mant[7i+6:7i], for i = 0..3, with out_prod[55:56-0] above lane 3 zero.
- mode 01: out_prod[28i+27:28i] = 14x14 product, for i = 0..1.
- mode 1x: out_prod = full 28x28 unsigned product.
- Bits not covered by a lane SHALL be 0.
REQ-022 SHALL never let lane carries propagate across lane boundaries in any mode.
REQ-023 SHALL carry mode through both stages, so that out_mode equals the mode sampled at input transfer.
REQ-024 SHALL accept an input and emit an output in the same cycle without loss or duplication.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously clear s1_valid, s2_valid and out_valid to 0.
REQ-026 SHALL, while rst_n=0, clear out_s, out_sc, out_prod and out_mode to 0, and hold in_ready at 1.
REQ-027 SHALL discard any in-flight operations when reset is asserted mid-operation; no result for them appears after reset release.

Configuration
REQ-028 SHALL behave as follows when POSIT_MULT_PERF_CNT_EN is defined:
- Add output port perf_cnt, 32 bits.
- perf_cnt increments by 1 on each output transfer and wraps from 0xFFFFFFFF to 0.
- perf_cnt resets to 0.
REQ-029 SHALL have no perf_cnt port and no counter logic when POSIT_MULT_PERF_CNT_EN is undefined; all other behaviour is identical.

Verification
REQ-030 SHALL cover mode 1x with a_mant = b_mant = 28'h8000000, a_rg_exp = 16'h0003, b_rg_exp = 16'hFFFE, a_s = 4'h8, b_s = 4'h0, out_ready = 1.
- Required response, 2 cycles later: out_prod = 56'h40000000000000, out_sc = 20'h00001, out_s[3] = 1.
REQ-031 SHALL cover mode 00 with all a and b mantissa lanes = 7'h7F and rg_exp lanes a = 4'h7, b = 4'h7.
- Required response: each 14-bit product lane = 14'h3F01, each sc lane = 5'h0E, out_prod[55:56] = 0, with no inter-lane carry.
REQ-032 SHALL cover mode 01 with lane 0 = 14'h3FFF x 14'h3FFF and lane 1 = 14'h2000 x 14'h2000.
- Required response: out_prod[27:0] = 28'hFFF8001 and out_prod[55:28] = 28'h4000000.
REQ-033 SHALL cover backpressure: 3 back-to-back inputs with out_ready = 0.
- Required response: in_ready drops after 2 accepted inputs, out_* stay stable, and releasing out_ready yields the 3 results in order with none lost.
REQ-034 SHALL cover reset during flight: assert rst_n = 0 one cycle after an input transfer.
- Required response: out_valid = 0 immediately, and no output appears after release.
REQ-035 SHALL cover the counter when POSIT_MULT_PERF_CNT_EN is defined: preload to 0xFFFFFFFE by forcing, then perform 3 output transfers.
- Required response: perf_cnt sequence 0xFFFFFFFF, 0x00000000, 0x00000001.
